serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request to add a, b, cin; sampled only when accepted (REQ-010).
REQ-005 The block SHALL have port a  input  WIDTH  addend A, unsigned/two's complement.
REQ-006 The block SHALL have port b  input  WIDTH  addend B.
REQ-007 The block SHALL have port cin  input  1  carry-in to bit 0.
REQ-008 The block SHALL have ports sum  output  WIDTH  registered result; busy  output  1  high while computing; done  output  1  one-cycle result-valid pulse; cout  output  1  registered carry-out of MSB.

Function
REQ-009 The block SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-010 Start SHALL be accepted on an edge where start=1 and state is IDLE or DONE; on acceptance a, b, cin are captured into internal shift registers/carry flop, bit counter cleared, state -> RUN.
REQ-011 start=1 while in RUN SHALL be ignored; captured operands and progress unaffected.
REQ-012 Each RUN edge SHALL compute one full-adder bit, LSB first: s_i = a_i ^ b_i ^ c, c' = a_i&b_i | c&(a_i^b_i); s_i shifted into internal result register, carry flop updated.
REQ-013 After exactly WIDTH RUN edges the FSM SHALL go to DONE; on that edge sum <= full WIDTH-bit result, cout <= final carry.
REQ-014 Latency: done SHALL be high in the cycle following the edge WIDTH clocks after the accepting edge; done high for exactly one cycle.
REQ-015 From DONE the FSM SHALL go to IDLE if start=0, or to RUN (new operation) if start=1; back-to-back throughput = one result per WIDTH+1 cycles.
REQ-016 sum and cout SHALL hold their last values in IDLE and RUN until the next DONE entry; they never show partial results.
REQ-017 Result SHALL equal (a + b + cin) mod 2^WIDTH, cout = bit WIDTH of a + b + cin, for all operand values including all-ones and zero.
REQ-018 Input changes on a, b, cin after the accepting edge SHALL NOT affect the running operation.

Reset
REQ-019 With rst=1 at a rising edge: state=IDLE, sum=0, cout=0, busy=0, done=0, bit counter=0, internal registers=0.
REQ-020 rst SHALL take priority over start and over any in-progress RUN; an interrupted operation is abandoned, no done pulse issued.
REQ-021 start asserted in the same cycle as rst SHALL be ignored; first acceptance possible on the first edge with rst=0.

Configuration
REQ-022 Macro SERIAL_ADDER_OVF_EN SHALL, when defined, add port ovf  output  1  registered signed overflow, updated on DONE entry: ovf = carry into MSB XOR carry out of MSB; reset value 0; held like sum.
REQ-023 Without SERIAL_ADDER_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-024 rst 2 cycles, then start with a=8'h0F, b=8'h01, cin=0 -> busy high 8 cycles, done pulse 8 edges after acceptance, sum=8'h10, cout=0.
REQ-025 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
REQ-026 With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
REQ-027 Start a=8'h05, b=8'h03, then start=1 with a=8'hAA, b=8'h55 during RUN cycle 3 -> ignored, result sum=8'h08, single done pulse.
REQ-028 Assert rst at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
REQ-029 start held high through DONE with new operands a=8'h10, b=8'h20 -> DONE lasts one cycle, immediately RUN again, second done after 8 more edges with sum=8'h30; random 1000-operation sweep matches a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder bit per clock, LSB first.
// Computes (a + b + cin) mod 2^WIDTH plus carry-out over WIDTH RUN cycles.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..64), default 8
//
// Ports:
//   clk    in   sole clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request; accepted only in IDLE or DONE
//   a, b   in   WIDTH-bit addends, captured on the accepting edge
//   cin    in   carry-in to bit 0, captured on the accepting edge
//   sum    out  registered WIDTH-bit result, updated only on DONE entry
//   busy   out  high while in RUN
//   done   out  one-cycle result-valid pulse (state DONE)
//   cout   out  registered carry-out of the MSB
//   ovf    out  registered signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Build option:
//   SERIAL_ADDER_OVF_EN  when defined, adds the ovf output and its logic.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             busy,
    output logic             done,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // Operand shift registers; bit 0 is always the bit being added.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    // Holds the WIDTH-1 result bits produced so far, filled from the top.
    logic [WIDTH-2:0] r_acc;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_acc_full;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One full-adder bit per RUN cycle
    // ------------------------------------------------------------------
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_s        = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c        = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

    // On the last bit this is the complete result: new MSB above the
    // WIDTH-1 bits already collected.
    assign w_acc_full = {w_s, r_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_busy) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_c   <= w_c;
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc_full[WIDTH-1:1];
            if (w_last) begin
                r_sum  <= w_acc_full;
                r_cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
                // r_c is the carry into the MSB on the final bit.
                r_ovf  <= r_c ^ w_c;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = w_busy;
    assign done = w_done;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// Scoreboard queue holds expected {ovf,cout,sum}, popped on each done pulse.

module tb_serial_adder;

    localparam int W   = 8;
    localparam int TMO = 4 * W;

    typedef logic [W+1:0] exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         busy;
    logic         done;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .busy  (busy),
        .done  (done),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    // Reference: {signed ovf, cout, sum} of x + y + c.
    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic         c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {v, t};
    endfunction

    // Called right after a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [W-1:0] x,
                         input logic [W-1:0] y,
                         input logic         c);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        q.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, scrambling operands to show they are not re-sampled.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %b expected 0", {busy, done, cout, sum}); end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0)
            begin errors++; $display("FAIL reset_start_ignored: busy=%b done=%b sum=%h expected 0 0 00", busy, done, sum); end
    endtask

    task automatic test_basic;
        int   n;
        int   nb;
        exp_t e;
        issue(8'h0F, 8'h01, 1'b0);
        nb = (busy === 1'b1) ? 1 : 0;
        n  = 0;
        while (done !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) nb++;
            a = W'($urandom);
            b = W'($urandom);
        end
        checks++;
        if (nb != W)
            begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", nb, W); end
        checks++;
        if (n != W)
            begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, W); end
        e = q.size() > 0 ? q.pop_front() : 'x;
        checks++;
        if ({cout, sum} !== 9'h010 || {cout, sum} !== e[W:0])
            begin errors++; $display("FAIL basic_result: got %h expected %h", {cout, sum}, 9'h010); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10)
            begin errors++; $display("FAIL basic_pulse_hold: done=%b busy=%b sum=%h expected 0 0 10", done, busy, sum); end
    endtask

    task automatic test_boundary;
        logic [W-1:0] va[5] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] vb[5] = '{8'h01, 8'h00, 8'hFF, 8'h00, 8'h00};
        logic         vc[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W:0]   prev;
        exp_t         e;
        int           n;
        for (int i = 0; i < 5; i++) begin
            prev = {cout, sum};
            issue(va[i], vb[i], vc[i]);
            checks++;
            if ({cout, sum} !== prev)
                begin errors++; $display("FAIL boundary_hold_%0d: got %h expected %h", i, {cout, sum}, prev); end
            wait_done(n);
            checks++;
            if (n >= TMO) begin
                errors++;
                $display("FAIL boundary_timeout_%0d: got no done expected done", i);
                q.delete();
            end else begin
                e = q.size() > 0 ? q.pop_front() : 'x;
                if ({cout, sum} !== e[W:0])
                    begin errors++; $display("FAIL boundary_%0d: got %h expected %h", i, {cout, sum}, e[W:0]); end
            end
            @(negedge clk);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        logic [W-1:0] va[4] = '{8'h7F, 8'h80, 8'h40, 8'h80};
        logic [W-1:0] vb[4] = '{8'h01, 8'h80, 8'h40, 8'h7F};
        exp_t         e;
        int           n;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 1'b0);
            wait_done(n);
            checks++;
            if (n >= TMO) begin
                errors++;
                $display("FAIL ovf_timeout_%0d: got no done expected done", i);
                q.delete();
            end else begin
                e = q.size() > 0 ? q.pop_front() : 'x;
                if ({ovf, cout, sum} !== e)
                    begin errors++; $display("FAIL ovf_%0d: got %h expected %h", i, {ovf, cout, sum}, e); end
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_ignore_start;
        int   pulses;
        exp_t e;
        pulses = 0;
        issue(8'h05, 8'h03, 1'b0);
        for (int i = 1; i <= W + 4; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else if (i == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                e = q.size() > 0 ? q.pop_front() : 'x;
                checks++;
                if ({cout, sum} !== e[W:0] || sum !== 8'h08)
                    begin errors++; $display("FAIL ignore_result: got %h expected %h", {cout, sum}, 9'h008); end
            end
        end
        checks++;
        if (pulses != 1)
            begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
        q.delete();
    endtask

    task automatic test_reset_abort;
        int pulses;
        pulses = 0;
        issue(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0)
            begin errors++; $display("FAIL abort_state: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy, done, sum, cout); end
        q.delete();
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0)
            begin errors++; $display("FAIL abort_activity: got %0d expected 0", pulses); end
    endtask

    task automatic test_back_to_back;
        int   n;
        exp_t e;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        q.push_back(model(8'h01, 8'h02, 1'b0));
        @(negedge clk);
        a   = 8'h10;
        b   = 8'h20;
        cin = 1'b0;
        q.push_back(model(8'h10, 8'h20, 1'b0));
        n = 0;
        while (done !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != W)
            begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", n, W); end
        e = q.size() > 0 ? q.pop_front() : 'x;
        checks++;
        if ({cout, sum} !== e[W:0] || sum !== 8'h03)
            begin errors++; $display("FAIL b2b_first: got %h expected %h", {cout, sum}, 9'h003); end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_rerun: done=%b busy=%b expected 0 1", done, busy); end
        wait_done(n);
        checks++;
        if (n != W)
            begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", n, W); end
        e = q.size() > 0 ? q.pop_front() : 'x;
        checks++;
        if ({cout, sum} !== e[W:0] || sum !== 8'h30)
            begin errors++; $display("FAIL b2b_second: got %h expected %h", {cout, sum}, 9'h030); end
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_random;
        int           n;
        exp_t         e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            issue(x, y, c);
            wait_done(n);
            checks++;
            if (n >= TMO) begin
                errors++;
                $display("FAIL random_timeout_%0d: got no done expected done", i);
                q.delete();
            end else begin
                e = q.size() > 0 ? q.pop_front() : 'x;
                if ({cout, sum} !== e[W:0])
                    begin errors++; $display("FAIL random_%0d: %h+%h+%b got %h expected %h", i, x, y, c, {cout, sum}, e[W:0]); end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_boundary;
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf;
`endif
        test_ignore_start;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
